// File: rtl/mem_responder.sv
// Single-port word memory behind a cyc/ack/err handshake with LATENCY wait states.
// Strobe arrives LATENCY+1 edges after acceptance; initiator stalls by holding cyc_m2s until the strobe.
module mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cyc_m2s,
    input  logic              we_m2s,
    input  logic [ADDR_W-1:0] adr_m2s,
    input  logic [DATA_W-1:0] dat_m2s,
    output logic [DATA_W-1:0] dat_mem_o,
    output logic              ack_mem_o,
    output logic              err_mem_o
);
    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0]      LAT     = 4'(LATENCY);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_RELEASE} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    logic [3:0]        cnt;
    logic              req_we;
    logic [ADDR_W-1:0] req_adr;
    logic [DATA_W-1:0] req_dat;
    logic              in_range;
    logic [IDX_W-1:0]  idx;

    logic              wr_en;
    logic              wr_we;
    logic [ADDR_W-1:0] wr_adr;
    logic [DATA_W-1:0] wr_dat;

    assign in_range = ({1'b0, req_adr} < DEPTH_V);
    assign idx      = req_adr[IDX_W-1:0];

    // The write commits on the edge that enters DONE; with zero latency that
    // is the accepting edge itself, so the live request fields are used.
    always_comb begin
        wr_en  = 1'b0;
        wr_we  = req_we;
        wr_adr = req_adr;
        wr_dat = req_dat;
        if (state == S_IDLE && cyc_m2s && LAT == 4'd0) begin
            wr_en  = 1'b1;
            wr_we  = we_m2s;
            wr_adr = adr_m2s;
            wr_dat = dat_m2s;
        end else if (state == S_WAIT && cnt == 4'd1) begin
            wr_en  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en && wr_we && ({1'b0, wr_adr} < DEPTH_V))
            mem[wr_adr[IDX_W-1:0]] <= wr_dat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            req_we    <= 1'b0;
            req_adr   <= '0;
            req_dat   <= '0;
            ack_mem_o <= 1'b0;
            err_mem_o <= 1'b0;
            dat_mem_o <= '0;
        end else begin
            ack_mem_o <= 1'b0;
            err_mem_o <= 1'b0;
            dat_mem_o <= '0;
            case (state)
                S_IDLE: begin
                    if (cyc_m2s) begin
                        req_we  <= we_m2s;
                        req_adr <= adr_m2s;
                        req_dat <= dat_m2s;
                        cnt     <= LAT;
                        state   <= (LAT == 4'd0) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    // The final wait edge wins over a dropped cyc: completion is already committed.
                    if (cnt == 4'd1) begin
                        cnt   <= 4'd0;
                        state <= S_DONE;
                    end else if (!cyc_m2s) begin
                        cnt   <= 4'd0;
                        state <= S_IDLE;
                    end else begin
                        cnt   <= cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    state <= S_RELEASE;
                    if (in_range) begin
                        ack_mem_o <= 1'b1;
                        if (!req_we)
                            dat_mem_o <= mem[idx];
                    end else begin
                        err_mem_o <= 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (!cyc_m2s)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Drives two responders (LATENCY 0 and 2, DEPTH 200) with independent request streams.
module tb_mem_responder;
    localparam int DEPTH = 200;
    localparam int LAT0  = 0;
    localparam int LAT1  = 2;

    typedef struct {
        int          cyc;
        bit          err;
        bit          chk_dat;
        logic [31:0] dat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        cyc  [2];
    logic        we   [2];
    logic [7:0]  adr  [2];
    logic [31:0] wdat [2];
    logic [31:0] rdat [2];
    logic        ack  [2];
    logic        err  [2];

    int          edge_n   = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          running  = 0;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] mem_m [2][256];
    bit          known [2][256];
    logic [7:0]  pool  [8] = '{8'h10, 8'h20, 8'h30, 8'h05, 8'hC7, 8'hC8, 8'hF0, 8'hFF};

    mem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(DEPTH), .LATENCY(LAT0)) u_l0 (
        .clk(clk), .rst(rst), .cyc_m2s(cyc[0]), .we_m2s(we[0]), .adr_m2s(adr[0]),
        .dat_m2s(wdat[0]), .dat_mem_o(rdat[0]), .ack_mem_o(ack[0]), .err_mem_o(err[0]));

    mem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(DEPTH), .LATENCY(LAT1)) u_l2 (
        .clk(clk), .rst(rst), .cyc_m2s(cyc[1]), .we_m2s(we[1]), .adr_m2s(adr[1]),
        .dat_m2s(wdat[1]), .dat_mem_o(rdat[1]), .ack_mem_o(ack[1]), .err_mem_o(err[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic void chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s dut%0d @edge %0d: got %h expected %h", nm, d, edge_n, act, exp_v);
        end
    endfunction

    // Transaction-level model: a request held for h sampled edges completes iff h >= LATENCY,
    // with its strobe in the cycle after edge accept+LATENCY+1.
    function automatic void expect_txn(input int d, input int acc, input int h, input bit w,
                                       input logic [7:0] a, input logic [31:0] v);
        exp_t e;
        int   lat;
        lat = (d == 0) ? LAT0 : LAT1;
        if (h < lat) return;
        e.cyc     = acc + lat + 1;
        e.err     = (int'(a) >= DEPTH);
        e.chk_dat = 1'b1;
        e.dat     = 32'h0;
        if (!e.err) begin
            if (w) begin
                mem_m[d][a] = v;
                known[d][a] = 1'b1;
            end else begin
                e.chk_dat = known[d][a];
                e.dat     = mem_m[d][a];
            end
        end
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endfunction

    task automatic txn(input int d, input bit w, input logic [7:0] a, input logic [31:0] v,
                       input int h, input int extra);
        int lat, acc, g;
        lat = (d == 0) ? LAT0 : LAT1;
        @(posedge clk); #1;
        we[d] = w; adr[d] = a; wdat[d] = v; cyc[d] = 1'b1;
        acc = edge_n + 1;
        expect_txn(d, acc, h, w, a, v);
        repeat (h) begin
            @(posedge clk); #1;
            we[d]   = 1'($urandom);
            adr[d]  = 8'($urandom);
            wdat[d] = $urandom;
        end
        cyc[d] = 1'b0;
        g = (lat + 3 - h > 1) ? lat + 3 - h : 1;
        g += extra;
        repeat (g - 1) @(posedge clk);
    endtask

    task automatic run(input int d);
        for (int i = 0; i < 8; i++)
            if (int'(pool[i]) < DEPTH) txn(d, 1'b1, pool[i], $urandom, 4, 0);
        txn(d, 1'b1, 8'h10, 32'hDEADBEEF, 4, 0);
        txn(d, 1'b0, 8'h10, 32'h0, 3, 0);
        txn(d, 1'b0, 8'hF0, 32'h0, 3, 0);
        txn(d, 1'b1, 8'hF0, 32'h12345678, 3, 0);
        txn(d, 1'b1, 8'h20, 32'h1, 1, 0);
        txn(d, 1'b0, 8'h20, 32'h0, 3, 0);
        txn(d, 1'b1, 8'h05, 32'hA5A50001, 2, 0);
        txn(d, 1'b1, 8'hC7, 32'hA5A50002, 2, 0);
        txn(d, 1'b0, 8'h05, 32'h0, 2, 0);
        txn(d, 1'b0, 8'hC7, 32'h0, 2, 0);
        repeat (50)
            txn(d, 1'($urandom), pool[$urandom_range(0, 7)], $urandom,
                $urandom_range(1, 5), $urandom_range(0, 2));
    endtask

    // Monitor: every strobe must match the head of the expectation queue at its due cycle.
    always @(negedge clk) begin
        exp_t e;
        bit   have, due, strobe;
        if (running && !rst) begin
            for (int d = 0; d < 2; d++) begin
                have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
                if (have) e = (d == 0) ? q0[0] : q1[0];
                due    = have && (e.cyc == edge_n);
                strobe = ack[d] | err[d];
                chk("ack_err_exclusive", d, 32'(ack[d] & err[d]), 32'h0);
                chk("strobe_timing", d, 32'(strobe), 32'(due));
                if (strobe && due) begin
                    chk("ack", d, 32'(ack[d]), 32'(!e.err));
                    chk("err", d, 32'(err[d]), 32'(e.err));
                    if (e.chk_dat) chk("rdata", d, rdat[d], e.dat);
                end else if (!strobe) begin
                    chk("idle_data_zero", d, rdat[d], 32'h0);
                end
                if (due) begin
                    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                end
            end
        end
    end

    initial begin
        exp_t e;
        int   acc;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            cyc[d] = 1'b0; we[d] = 1'b0; adr[d] = 8'h0; wdat[d] = 32'h0;
        end
        #1 rst = 1'b1;
        #2;
        for (int d = 0; d < 2; d++) begin
            chk("reset_ack", d, 32'(ack[d]), 32'h0);
            chk("reset_err", d, 32'(err[d]), 32'h0);
            chk("reset_dat", d, rdat[d], 32'h0);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        running = 1'b1;

        fork
            run(0);
            run(1);
        join

        // Reset pulse: lat-2 write to 0x30 is mid-wait, lat-0 read is presenting its ack.
        @(posedge clk); #1;
        we[0] = 1'b0; adr[0] = 8'h10; cyc[0] = 1'b1;
        we[1] = 1'b1; adr[1] = 8'h30; wdat[1] = 32'hBAD0BAD0; cyc[1] = 1'b1;
        acc = edge_n + 1;
        e.cyc = acc + 1; e.err = 1'b0; e.chk_dat = known[0][8'h10]; e.dat = mem_m[0][8'h10];
        q0.push_back(e);
        @(posedge clk);
        @(posedge clk);
        #6;
        rst = 1'b1; cyc[0] = 1'b0; cyc[1] = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("async_rst_ack", d, 32'(ack[d]), 32'h0);
            chk("async_rst_err", d, 32'(err[d]), 32'h0);
            chk("async_rst_dat", d, rdat[d], 32'h0);
        end
        #1 rst = 1'b0;

        txn(1, 1'b0, 8'h30, 32'h0, 3, 0);
        txn(0, 1'b0, 8'h30, 32'h0, 3, 0);
        txn(1, 1'b0, 8'h10, 32'h0, 2, 0);

        repeat (10) @(posedge clk);
        chk("drain_q0", 0, 32'(q0.size()), 32'h0);
        chk("drain_q1", 1, 32'(q1.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 8, address width in bits.
REQ-002 Parameter DATA_W, default 32, data word width in bits.
REQ-003 Parameter DEPTH, default 256, number of implemented words (DEPTH <= 2**ADDR_W).
REQ-004 Parameter LATENCY, default 2, wait-state cycles inserted before completion (0..15).
REQ-005 clk  input  1  single clock; all sequential logic on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 cyc_m2s  input  1  bus cycle request from the initiator.
REQ-008 we_m2s  input  1  1 = write, 0 = read; sampled with cyc_m2s.
REQ-009 adr_m2s  input  ADDR_W  word address; sampled with cyc_m2s.
REQ-010 dat_m2s  input  DATA_W  write data; sampled with cyc_m2s.
REQ-011 dat_mem_o  output  DATA_W  read data to the initiator.
REQ-012 ack_mem_o  output  1  successful completion strobe.
REQ-013 err_mem_o  output  1  error completion strobe (address out of range).

Function
REQ-014 Storage: DEPTH x DATA_W word array; contents not cleared by rst.
REQ-015 FSM states: IDLE, WAIT, DONE, RELEASE; registered, one-hot or binary at implementer's choice.
REQ-016 IDLE: on rising edge with cyc_m2s=1, capture we_m2s, adr_m2s, dat_m2s into request registers, load wait counter with LATENCY; go to WAIT if LATENCY>0, else to DONE.
REQ-017 WAIT: counter decrements by 1 per cycle; on the edge where counter equals 1, go to DONE.
REQ-018 DONE: lasts exactly one cycle; ack_mem_o or err_mem_o is high for that cycle only; then go to RELEASE.
REQ-019 Latency: cyc_m2s sampled high at edge N -> completion strobe high during cycle after edge N+LATENCY+1... precisely, strobe asserted from edge N+LATENCY+1 to edge N+LATENCY+2.
REQ-020 RELEASE: remain until cyc_m2s sampled low, then go to IDLE; a held-high cyc_m2s never starts a second transaction.
REQ-021 Minimum spacing: new request is accepted no earlier than the edge after cyc_m2s is sampled low.
REQ-022 Write: array updated with captured data at the edge entering DONE; only when captured address < DEPTH.
REQ-023 Read: dat_mem_o = array[captured address] while ack_mem_o=1; dat_mem_o = 0 at all other times.
REQ-024 Write completion: ack_mem_o=1, dat_mem_o=0.
REQ-025 Out of range (captured address >= DEPTH): err_mem_o=1 instead of ack_mem_o, no array write, dat_mem_o=0.
REQ-026 ack_mem_o and err_mem_o are never high in the same cycle.
REQ-027 Abort: cyc_m2s sampled low while in WAIT -> return to IDLE, no write, no strobe.
REQ-028 cyc_m2s dropping in the same edge that enters DONE does not cancel the completion; the write still commits and the strobe still fires.
REQ-029 Request inputs are ignored outside IDLE; changes during WAIT do not affect the captured transaction.
REQ-030 All outputs registered; no combinational path from any input to any output.

Reset
REQ-031 rst=1 forces, asynchronously: state IDLE, counter 0, ack_mem_o=0, err_mem_o=0, dat_mem_o=0.
REQ-032 rst asserted mid-transaction discards the pending request; no array write occurs for it.
REQ-033 After rst deasserts, first request is accepted on the first rising edge with cyc_m2s=1.

Verification
REQ-034 Write adr=0x10 dat=0xDEADBEEF, LATENCY=2, cyc held 4 cycles -> ack_mem_o high exactly 1 cycle, 3 edges after cyc sampled; no second ack while cyc stays high.
REQ-035 Read adr=0x10 after REQ-034 scenario -> ack_mem_o=1 with dat_mem_o=0xDEADBEEF in the same cycle; dat_mem_o=0 before and after.
REQ-036 DEPTH=200, read adr=0xF0 -> err_mem_o=1 one cycle, ack_mem_o=0, dat_mem_o=0; write to 0xF0 leaves array unchanged.
REQ-037 Write adr=0x20 dat=0x1, cyc dropped one edge after acceptance (LATENCY=2) -> no strobe; subsequent read of 0x20 returns prior value.
REQ-038 rst pulsed asynchronously during WAIT of write 0x30 -> outputs 0 immediately, no strobe; later read of 0x30 returns prior value.
REQ-039 LATENCY=0, back-to-back writes with cyc low for one cycle between -> ack 1 edge after each acceptance; both words readable.
